// File: rtl/kgd_scanout_pkg.sv
// Shared SVGA 800x600@72 video timing constants and KGD window geometry.
// Used by every scanout that shares the SVGA timing generator.
package kgd_scanout_pkg;

  localparam int unsigned H_VISIBLE = 800;
  localparam int unsigned H_FRONT   = 56;
  localparam int unsigned H_SYNC    = 120;
  localparam int unsigned H_BACK    = 64;
  localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int unsigned V_VISIBLE = 600;
  localparam int unsigned V_FRONT   = 37;
  localparam int unsigned V_SYNC    = 6;
  localparam int unsigned V_BACK    = 23;
  localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam int unsigned KGD_W = 400;
  localparam int unsigned KGD_H = 286;

  localparam int unsigned HCNT_W = 11;
  localparam int unsigned VCNT_W = 10;
  localparam int unsigned ADDR_W = 17;

  typedef logic [HCNT_W-1:0] hcnt_t;
  typedef logic [VCNT_W-1:0] vcnt_t;
  typedef logic [ADDR_W-1:0] addr_t;

  localparam hcnt_t H_VIS_END    = hcnt_t'(H_VISIBLE);
  localparam hcnt_t H_SYNC_FIRST = hcnt_t'(H_VISIBLE + H_FRONT);
  localparam hcnt_t H_SYNC_LAST  = hcnt_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam hcnt_t H_LAST       = hcnt_t'(H_TOTAL - 1);

  localparam vcnt_t V_SYNC_FIRST = vcnt_t'(V_VISIBLE + V_FRONT);
  localparam vcnt_t V_SYNC_LAST  = vcnt_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam vcnt_t V_LAST       = vcnt_t'(V_TOTAL - 1);

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic window;
    logic frame;
  } scan_flags_t;

  function automatic vcnt_t wrap_line(int unsigned line);
    return vcnt_t'(line % V_TOTAL);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// SVGA horizontal/vertical counters with raw (undelayed) sync and visible decode.
module vga_timing
  import kgd_scanout_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  output logic [HCNT_W-1:0] hcnt,
  output logic [VCNT_W-1:0] vcnt,
  output logic              line_end,
  output logic              hsync_raw,
  output logic              vsync_raw,
  output logic              h_visible
);

  hcnt_t hcnt_q, hcnt_d;
  vcnt_t vcnt_q, vcnt_d;

  always_comb begin
    line_end = (hcnt_q == H_LAST);
    hcnt_d   = line_end ? '0 : hcnt_q + HCNT_W'(1);
    vcnt_d   = vcnt_q;
    if (line_end) begin
      vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + VCNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  always_comb begin
    hsync_raw = (hcnt_q >= H_SYNC_FIRST) && (hcnt_q <= H_SYNC_LAST);
    vsync_raw = (vcnt_q >= V_SYNC_FIRST) && (vcnt_q <= V_SYNC_LAST);
    h_visible = (hcnt_q < H_VIS_END);
  end

  assign hcnt = hcnt_q;
  assign vcnt = vcnt_q;

endmodule

// File: rtl/kgd_scanout.sv
// KGD 400x286 monochrome framebuffer scanout, pixel-doubled into SVGA 800x600@72.
// Generates video RAM addresses and aligns syncs with the RAM read latency.
module kgd_scanout
  import kgd_scanout_pkg::*;
#(
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned V_OFFSET = 14
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              en,
  input  logic              inv,
  output logic [ADDR_W-1:0] address_b,
  input  logic              q_b,
  output logic              hsync,
  output logic              vsync,
  output logic              pixel,
  output logic              frame
);

  // One stage for the address register plus the RAM read latency.
  localparam int unsigned DEPTH = RD_LAT + 1;

  localparam vcnt_t WIN_TOP       = vcnt_t'(V_OFFSET);
  localparam vcnt_t WIN_END       = vcnt_t'(V_OFFSET + 2 * KGD_H);
  localparam vcnt_t BASE_CLR_LINE = wrap_line(V_OFFSET + V_TOTAL - 1);
  localparam addr_t ROW_STEP      = addr_t'(KGD_W);

  hcnt_t hcnt;
  vcnt_t vcnt;
  logic  line_end;
  logic  hsync_raw;
  logic  vsync_raw;
  logic  h_visible;

  vga_timing u_timing (
    .clock     (clock),
    .reset     (reset),
    .hcnt      (hcnt),
    .vcnt      (vcnt),
    .line_end  (line_end),
    .hsync_raw (hsync_raw),
    .vsync_raw (vsync_raw),
    .h_visible (h_visible)
  );

  logic                     v_window;
  logic                     window;
  logic                     row_odd;
  scan_flags_t              raw_flags;
  scan_flags_t              out_flags;
  scan_flags_t [DEPTH-1:0]  pipe_q;
  addr_t                    line_base_q, line_base_d;
  addr_t                    address_q, address_d;

  always_comb begin
    v_window = (vcnt >= WIN_TOP) && (vcnt < WIN_END);
    window   = h_visible && v_window;
    // Parity of (vcnt - V_OFFSET) without a subtractor.
    row_odd  = vcnt[0] ^ WIN_TOP[0];

    raw_flags.hsync  = hsync_raw;
    raw_flags.vsync  = vsync_raw;
    raw_flags.window = window;
    raw_flags.frame  = (hcnt == '0) && (vcnt == V_SYNC_FIRST);

    // Each source row is shown twice, so advance the base after the second copy.
    line_base_d = line_base_q;
    if (line_end) begin
      if (vcnt == BASE_CLR_LINE) begin
        line_base_d = '0;
      end else if (v_window && row_odd) begin
        line_base_d = line_base_q + ROW_STEP;
      end
    end

    address_d = window ? line_base_q + addr_t'(hcnt[9:1]) : address_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      line_base_q <= '0;
      address_q   <= '0;
      pipe_q      <= '0;
    end else begin
      line_base_q <= line_base_d;
      address_q   <= address_d;
      pipe_q      <= {pipe_q[DEPTH-2:0], raw_flags};
    end
  end

  assign out_flags = pipe_q[DEPTH-1];
  assign address_b = address_q;
  assign hsync     = out_flags.hsync;
  assign vsync     = out_flags.vsync;
  assign frame     = out_flags.frame;
  assign pixel     = out_flags.window & en & (q_b ^ inv);

endmodule

// File: tb/tb_kgd_scanout.sv
// Scoreboard bench for kgd_scanout: RD_LAT=1 and RD_LAT=2 instances against a position model.
module tb_kgd_scanout;

  localparam int unsigned V_OFF = 14;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b1;
  logic        inv = 1'b0;
  logic        tie_one = 1'b0;
  logic [16:0] address_b, address_b2;
  logic        q_b, q_b2;
  logic        hsync, vsync, pixel, frame;
  logic        hsync2, vsync2, pixel2, frame2;
  logic        ram_q = 1'b0, ram2_p = 1'b0, ram2_q = 1'b0;
  logic [10:0] jh;
  logic [9:0]  jv;
  logic [16:0] jb;

  int unsigned cyc = 0;
  int          n_chk = 0, n_fail = 0, n_print = 0, n_frames = 0;
  int          mh = 0, mv = 0;

  typedef struct {
    int unsigned due;
    logic        rst;
    logic [3:0]  flags;  // {hsync, vsync, frame, pixel}
    logic        addr_chk;
    logic [16:0] addr;
    int          h;
    int          v;
  } exp_t;

  exp_t sb[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // RAM models: stored bit equals address bit 0, latency 1 and 2.
  always @(posedge clock) begin
    ram_q  <= address_b[0];
    ram2_p <= address_b2[0];
    ram2_q <= ram2_p;
  end
  assign q_b  = tie_one ? 1'b1 : ram_q;
  assign q_b2 = tie_one ? 1'b1 : ram2_q;

  kgd_scanout #(.RD_LAT(1), .V_OFFSET(V_OFF)) dut (
    .clock(clock), .reset(reset), .en(en), .inv(inv), .address_b(address_b), .q_b(q_b),
    .hsync(hsync), .vsync(vsync), .pixel(pixel), .frame(frame)
  );

  kgd_scanout #(.RD_LAT(2), .V_OFFSET(V_OFF)) dut2 (
    .clock(clock), .reset(reset), .en(en), .inv(inv), .address_b(address_b2), .q_b(q_b2),
    .hsync(hsync2), .vsync(vsync2), .pixel(pixel2), .frame(frame2)
  );

  task automatic check(string name, logic [31:0] got, logic [31:0] want, int h, int v);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      if (n_print < 100) begin
        n_print++;
        $display("FAIL %s at h=%0d v=%0d: got %0h, want %0h", name, h, v, got, want);
      end
    end
  endtask

  function automatic exp_t model(int h, int v);
    exp_t e;
    logic hs, vs, fr, win, abit;
    int   a;
    hs   = (h >= 856) && (h <= 975);
    vs   = (v >= 637) && (v <= 642);
    fr   = (h == 0) && (v == 637);
    win  = (h < 800) && (v >= V_OFF) && (v < V_OFF + 572);
    a    = win ? ((v - V_OFF) / 2) * 400 + h / 2 : 0;
    abit = tie_one ? 1'b1 : a[0];
    e.due      = cyc + 2;
    e.rst      = 1'b0;
    e.flags    = {hs, vs, fr, win & en & (abit ^ inv)};
    e.addr_chk = win;
    e.addr     = a[16:0];
    e.h        = h;
    e.v        = v;
    return e;
  endfunction

  task automatic advance();
    if (mh == 1039) begin
      mh = 0;
      mv = (mv == 665) ? 0 : mv + 1;
    end else begin
      mh++;
    end
  endtask

  // Per-line control, applied in horizontal blanking ahead of the line.
  task automatic set_cfg(int line);
    en = 1'b1;
    inv = 1'b0;
    tie_one = 1'b0;
    case (line - V_OFF)
      1: inv = 1'b1;
      2: en = 1'b0;
      3: begin tie_one = 1'b1; inv = 1'b1; end
      4: tie_one = 1'b1;
      default: ;
    endcase
  endtask

  task automatic step();
    @(negedge clock);
    if (mh == 900) set_cfg((mv == 665) ? 0 : mv + 1);
    sb.push_back(model(mh, mv));
    advance();
  endtask

  task automatic run_until(int tv, int th);
    while (!(mv == tv && mh == th)) step();
  endtask

  task automatic jump(int h, int v, logic [16:0] base);
    @(negedge clock);
    jh = 11'(h);
    jv = 10'(v);
    jb = base;
    force dut.u_timing.hcnt_q = jh;
    force dut.u_timing.vcnt_q = jv;
    force dut.line_base_q = jb;
    force dut2.u_timing.hcnt_q = jh;
    force dut2.u_timing.vcnt_q = jv;
    force dut2.line_base_q = jb;
    #1;
    release dut.u_timing.hcnt_q;
    release dut.u_timing.vcnt_q;
    release dut.line_base_q;
    release dut2.u_timing.hcnt_q;
    release dut2.u_timing.vcnt_q;
    release dut2.line_base_q;
    mh = h;
    mv = v;
    sb.push_back(model(mh, mv));
    advance();
  endtask

  task automatic hold_reset(int n);
    exp_t z;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      reset = 1'b1;
      // Outputs scheduled for after the reset edge are abandoned.
      while (sb.size() > 0 && sb[sb.size()-1].due > cyc) void'(sb.pop_back());
      z.due = cyc + 1;
      z.rst = 1'b1;
      z.flags = 4'b0000;
      z.addr_chk = 1'b1;
      z.addr = 17'd0;
      z.h = -1;
      z.v = -1;
      sb.push_back(z);
    end
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset = 1'b0;
    mh = 0;
    mv = 0;
    set_cfg(0);
    sb.push_back(model(mh, mv));
    advance();
  endtask

  initial begin : monitor
    exp_t        cur, prev;
    logic        popped;
    logic        prev_ok = 1'b0;
    logic [16:0] prev_addr = '0;
    forever begin
      @(posedge clock);
      #1;
      popped = 1'b0;
      while (sb.size() > 0 && sb[0].due < cyc) begin
        cur = sb.pop_front();
        check("schedule", cur.due, cyc, cur.h, cur.v);
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        cur = sb.pop_front();
        popped = 1'b1;
        check("sync_pixel_lat1", {28'd0, hsync, vsync, frame, pixel}, {28'd0, cur.flags},
              cur.h, cur.v);
        if (cur.addr_chk)
          check("address_b", {15'd0, cur.rst ? address_b : prev_addr}, {15'd0, cur.addr},
                cur.h, cur.v);
        if (cur.rst)
          check("sync_pixel_lat2_rst", {28'd0, hsync2, vsync2, frame2, pixel2}, 32'd0,
                cur.h, cur.v);
        else if (prev_ok && !prev.rst)
          check("sync_pixel_lat2", {28'd0, hsync2, vsync2, frame2, pixel2},
                {28'd0, prev.flags}, prev.h, prev.v);
      end
      prev_ok = popped;
      prev = cur;
      prev_addr = address_b;
      if (frame === 1'b1) n_frames++;
    end
  end

  initial begin : driver
    hold_reset(4);
    release_reset();
    // Lines 14..18 exercise the RAM pattern, inv, en=0 and tied-high data.
    run_until(19, 0);
    // Last two window lines: base for source row 285.
    jump(1030, V_OFF + 570, 17'd114000);
    run_until(V_OFF + 572, 20);
    // Full vertical sync, frame pulse and frame wrap.
    jump(1030, 636, 17'd0);
    run_until(1, 20);
    // Reset in the middle of vsync.
    jump(1030, 636, 17'd0);
    run_until(640, 300);
    hold_reset(3);
    release_reset();
    run_until(2, 0);
    repeat (4) @(negedge clock);
    check("frame_count", n_frames, 2, -1, -1);
    check("scoreboard_drained", sb.size(), 0, -1, -1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
